// File: rtl/mmio_button_port.sv
// mmio_button_port: memory-mapped port for the five debounced buttons and the display output word.
//
// Each button rise is held as a sticky event flag. A load from the button's
// address returns the flag and clears it. A store to ADDR_OUT updates the held
// display word and raises a one-cycle strobe.
//
// Optional feature: defining MMIO_PRESS_COUNT_EN adds a saturating press
// counter for each button. A load from the button address + 1 reads the
// counter and then clears it.
//
// Ports:
//   clock       system clock; all state changes on the rising edge
//   reset       asynchronous, active-high; clears all state
//   btn_db      debounced button levels {C,L,R,U,D}; bit 4 is C
//   dmem_addr   processor data-memory address
//   dmem_rd_en  load in the memory stage (only loads consume events)
//   dmem_wren   store in the memory stage (a store wins over a load)
//   dmem_wdata  store data
//   rd_data     registered read data
//   rd_hit      registered; rd_data is valid and overrides RAM data
//   out_data    held display word
//   out_strobe  one-cycle pulse when out_data is updated
//   pending     current sticky event flags
module mmio_button_port #(
`ifdef MMIO_PRESS_COUNT_EN
  parameter int unsigned CNT_W     = 8,
`endif
  parameter logic [31:0] ADDR_BTNC = 32'd1000,
  parameter logic [31:0] ADDR_OUT  = 32'd2000,
  parameter logic [31:0] ADDR_BTNL = 32'd3000,
  parameter logic [31:0] ADDR_BTNR = 32'd4000,
  parameter logic [31:0] ADDR_BTNU = 32'd5000,
  parameter logic [31:0] ADDR_BTND = 32'd6000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  btn_db,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_rd_en,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] rd_data,
  output logic        rd_hit,
  output logic [31:0] out_data,
  output logic        out_strobe,
  output logic [4:0]  pending
);

  localparam int unsigned NB = 5;

  logic [NB-1:0] prev;
  logic          armed;
  logic [NB-1:0] rise;
  logic [NB-1:0] sel;
  logic [NB-1:0] clr;
  logic          is_load;
  logic          rd_hit_nxt;
  logic [31:0]   rd_data_nxt;

`ifdef MMIO_PRESS_COUNT_EN
  logic [CNT_W-1:0] cnt [NB];
  logic [NB-1:0]    cnt_sel;
  logic [NB-1:0]    cnt_clr;
  logic [31:0]      cnt_rdata;
`endif

  // Address decode, edge detect, and the next value of the read result.
  always_comb begin
    is_load = dmem_rd_en & ~dmem_wren;
    // armed is low for the first clock after reset. This masks rises from
    // buttons held through reset while prev picks up the real levels.
    rise    = btn_db & ~prev & {NB{armed}};
    sel     = {dmem_addr == ADDR_BTNC, dmem_addr == ADDR_BTNL,
               dmem_addr == ADDR_BTNR, dmem_addr == ADDR_BTNU,
               dmem_addr == ADDR_BTND};
    clr     = sel & {NB{is_load}};
    rd_hit_nxt  = 1'b0;
    rd_data_nxt = '0;
`ifdef MMIO_PRESS_COUNT_EN
    cnt_sel   = {dmem_addr == ADDR_BTNC + 32'd1, dmem_addr == ADDR_BTNL + 32'd1,
                 dmem_addr == ADDR_BTNR + 32'd1, dmem_addr == ADDR_BTNU + 32'd1,
                 dmem_addr == ADDR_BTND + 32'd1};
    cnt_clr   = cnt_sel & {NB{is_load}};
    cnt_rdata = '0;
    for (int i = 0; i < NB; i++) begin
      if (cnt_sel[i]) cnt_rdata = 32'(cnt[i]);
    end
    if (|cnt_clr) begin
      rd_hit_nxt  = 1'b1;
      rd_data_nxt = cnt_rdata;
    end
`endif
    // A rise in the same cycle as the read is reported as set.
    if (|clr) begin
      rd_hit_nxt  = 1'b1;
      rd_data_nxt = {31'b0, |(sel & (pending | rise))};
    end
  end

  // Edge history, sticky flags, and the registered read port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev    <= '0;
      armed   <= 1'b0;
      pending <= '0;
      rd_hit  <= 1'b0;
      rd_data <= '0;
    end else begin
      prev    <= btn_db;
      armed   <= 1'b1;
      pending <= rise | (pending & ~clr);
      rd_hit  <= rd_hit_nxt;
      rd_data <= rd_data_nxt;
    end
  end

  // Display output register with a one-cycle update strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data   <= '0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= dmem_wren & (dmem_addr == ADDR_OUT);
      if (dmem_wren && dmem_addr == ADDR_OUT) out_data <= dmem_wdata;
    end
  end

`ifdef MMIO_PRESS_COUNT_EN
  // Saturating press counters. A read clears the counter, but a rise in the
  // same cycle leaves it at 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (cnt_clr[i])                  cnt[i] <= CNT_W'(rise[i]);
        else if (rise[i] && !(&cnt[i]))  cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: doc/mmio_button_port.md
Name: mmio_button_port

Overview:
- Memory-mapped I/O port between the five debounced buttons and the processor data-memory read path. Also covers the display-output register on the write path.
- Converts debounced button levels into sticky press events that are cleared when read.
- Claims addresses 1000, 3000, 4000, 5000 and 6000 for reads, and 2000 for writes. Presents registered read data plus a hit flag so the top level can select port data over RAM data.
- Latches processor stores to 2000 into a held output word with a one-cycle strobe for the VGA controller.

Parameters:
- ADDR_BTNC, 1000, read address of centre-button event
- ADDR_OUT, 2000, write address of display output word
- ADDR_BTNL, 3000, read address of left-button event
- ADDR_BTNR, 4000, read address of right-button event
- ADDR_BTNU, 5000, read address of up-button event
- ADDR_BTND, 6000, read address of down-button event
- CNT_W, 8, press-counter width (used only with the optional feature)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- btn_db  in  5  debounced button levels {C,L,R,U,D}, bit4 = C
- dmem_addr  in  32  processor data-memory address
- dmem_rd_en  in  1  load in memory stage; only loads consume events
- dmem_wren  in  1  store in memory stage
- dmem_wdata  in  32  store data
- rd_data  out  32  registered read data
- rd_hit  out  1  registered; rd_data is valid this cycle and overrides RAM data
- out_data  out  32  held display word
- out_strobe  out  1  one-cycle pulse when out_data is updated
- pending  out  5  current sticky event flags, for debug and LEDs

Behaviour:
- Reset values: rd_data=0, rd_hit=0, out_data=0, out_strobe=0, pending=0, previous-level register=0.
- Edge detect:
  - prev <= btn_db every cycle.
  - rise[i] = btn_db[i] & ~prev[i].
  - A button held through reset release produces no event until it is released and pressed again, because prev is loaded on the first clock after reset.
- Sticky flags, per button i each cycle: pending[i] <= rise[i] | (pending[i] & ~clr[i]).
  - clr[i] = dmem_rd_en & ~dmem_wren & (dmem_addr == ADDR of i).
  - A rise in the same cycle as a read clears the old event and sets the new one, so no press is lost. The read itself returns 1 because the old flag was set.
- Read path (latency 1):
  - On a rising edge with an address match for a button, rd_hit <= 1 and rd_data <= {31'b0, pending[i] | rise[i]}.
  - Otherwise rd_hit <= 0 and rd_data <= 0.
  - An address match while dmem_rd_en=0 gives no hit and no clear, so ALU results in the memory stage never consume events.
  - Only the exact 32-bit address matches; upper bits are not aliased.
- Write path:
  - dmem_wren & (dmem_addr == ADDR_OUT) -> out_data <= dmem_wdata and out_strobe <= 1 for exactly one cycle.
  - Back-to-back stores give consecutive strobes, with out_data updated each cycle.
  - Stores to button addresses are ignored: no flag change, no hit.
  - dmem_rd_en and dmem_wren both high counts as a store; no read occurs.
- Multiple buttons are independent; simultaneous rises set multiple flags.
- Reset asserted mid-operation immediately clears pending and outputs. Events in flight are discarded.

Optional Feature:
- Macro: MMIO_PRESS_COUNT_EN.
- Defined:
  - Each button has a CNT_W-bit saturating press counter, incremented on rise[i] and sticking at all-ones.
  - A load from ADDR+1 returns the zero-extended count with latency 1 and rd_hit, then clears the counter.
  - A rise in the same cycle as the count read leaves the counter at 1.
  - The address+1 locations are decoded only when the macro is defined.
- Undefined: no counters and no address+1 decode; a load from ADDR+1 gives rd_hit=0.

Test Plan:
- Reset, press BTNL once (rise), then load 3000 -> next cycle rd_hit=1, rd_data=1, pending[3]=0. Load 3000 again -> rd_data=0.
- BTNC rises in the same cycle as a load of 1000 with pending[4]=1 -> rd_data=1 and pending[4] stays 1. A second load returns 1, a third returns 0.
- dmem_addr=5000 with dmem_rd_en=0 for 10 cycles after a BTNU press -> rd_hit=0 throughout, pending[1]=1 retained.
- Store 0x0000_00A5 to 2000 -> out_data=0xA5 and out_strobe high for one cycle. Store to 4000 -> out_data unchanged, pending unchanged.
- Hold BTND high across reset deassertion -> no event; release and press -> pending[0]=1. Assert reset while pending=5'b11111 -> all 0 asynchronously.
- With MMIO_PRESS_COUNT_EN: 300 BTNR presses, load 4001 -> rd_data=255. Reload -> 0. Without the macro, load 4001 -> rd_hit=0.
